// File: rtl/oka_seq_mul.sv
// oka_seq_mul: digit-serial carry-less (GF(2)) multiplier, D bits of b per cycle.
// Produces the unreduced 2N-1 bit product of two N-bit binary polynomials in
// K = ceil(N/D) cycles after an accepted start.
// Build option: define OKA_SEQ_MUL_ACC_EN to add the acc input, which folds
// the new product into the previous y (y ^= a*b) instead of replacing it.
module oka_seq_mul #(
  parameter int unsigned N = 409,
  parameter int unsigned D = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
`ifdef OKA_SEQ_MUL_ACC_EN
  input  logic             acc,
`endif
  output logic             busy,
  output logic             done,
  output logic [2*N-2:0]   y
);

  localparam int unsigned K  = (N + D - 1) / D;
  localparam int unsigned CW = $clog2(K + 1);
  localparam int unsigned YW = 2 * N - 1;
  localparam int unsigned KD = K * D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nx;
  logic            accept_c;
  logic            last_c;

  logic [CW-1:0]   cnt;
  // a pre-shifted by cnt*D; never exceeds bit 2N-2 for any digit that can be nonzero
  logic [YW-1:0]   a_sh;
  // b zero-padded to K*D bits, consumed one digit per cycle from the bottom
  logic [KD-1:0]   b_sh;
  logic [YW-1:0]   prod_acc;
`ifdef OKA_SEQ_MUL_ACC_EN
  logic            acc_mode;
`endif

  logic [D-1:0]    dig_c;
  logic [YW-1:0]   ash_c;
  logic [YW-1:0]   pp_c;
  logic [YW-1:0]   sum_c;

  // State register plus registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nx = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == CW'(K - 1)) begin
          last_c   = 1'b1;
          state_nx = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept_c = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Carry-less partial product of the current digit and the aligned multiplicand
  always_comb begin
    dig_c = b_sh[D-1:0];
    ash_c = a_sh;
    pp_c  = '0;
    for (int unsigned j = 0; j < D; j++) begin
      if (dig_c[0]) begin
        pp_c = pp_c ^ ash_c;
      end
      dig_c = dig_c >> 1;
      ash_c = ash_c << 1;
    end
    sum_c = prod_acc ^ pp_c;
  end

  // Operand latch, digit stepping, accumulation and result load
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      a_sh     <= '0;
      b_sh     <= '0;
      prod_acc <= '0;
      y        <= '0;
`ifdef OKA_SEQ_MUL_ACC_EN
      acc_mode <= 1'b0;
`endif
    end else if (accept_c) begin
      cnt      <= '0;
      a_sh     <= YW'(a);
      b_sh     <= KD'(b);
      prod_acc <= '0;
`ifdef OKA_SEQ_MUL_ACC_EN
      acc_mode <= acc;
`endif
    end else if (state == RUN) begin
      cnt      <= cnt + CW'(1);
      a_sh     <= a_sh << D;
      b_sh     <= b_sh >> D;
      prod_acc <= sum_c;
      if (last_c) begin
`ifdef OKA_SEQ_MUL_ACC_EN
        y <= acc_mode ? (y ^ sum_c) : sum_c;
`else
        y <= sum_c;
`endif
      end
    end
  end

endmodule
